// File: rtl/phys_free_list.sv
// Physical-register free list for rename: speculative head, retirement head and tail over a circular buffer.
// Optional same-cycle release-to-allocate bypass on an empty list: define FREELIST_BYPASS_EN.
module phys_free_list #(
   parameter int NUM_ARCH_REGS = 16,
   parameter int NUM_PHYS_REGS = 32,
   parameter int PREG_W        = 5,
   parameter int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alloc_req,
   output logic                     alloc_valid,
   output logic [PREG_W-1:0]        alloc_preg,
   input  logic                     rel_valid,
   input  logic [PREG_W-1:0]        rel_preg,
   input  logic                     commit_valid,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   free_count,
   output logic                     overflow_err
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PREG_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  spec_head;
   logic [PTR_W-1:0]  retire_head;
   logic [PTR_W-1:0]  tail;

   logic [PTR_W-1:0]  count;
   logic              empty;
   logic              full;
   logic              bypass;
   logic              grant;
   logic              rel_accept;
   logic [PTR_W-1:0]  retire_next;

   assign count = tail - spec_head;
   assign empty = (count == '0);
   assign full  = (count == PTR_W'(DEPTH));

`ifdef FREELIST_BYPASS_EN
   assign bypass = empty & rel_valid & alloc_req;
`else
   assign bypass = 1'b0;
`endif

   assign alloc_valid = ~empty | bypass;
   assign alloc_preg  = bypass ? rel_preg : mem[spec_head[IDX_W-1:0]];
   assign free_count  = count;

   assign grant       = alloc_req & alloc_valid & ~flush;
   // When full, a same-cycle grant frees the slot the release overwrites (tail and spec_head share an index).
   assign rel_accept  = rel_valid & (~full | grant);
   assign retire_next = retire_head + PTR_W'(commit_valid);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= PREG_W'(NUM_ARCH_REGS + i);
         end
         spec_head    <= '0;
         retire_head  <= '0;
         tail         <= PTR_W'(DEPTH);
         overflow_err <= 1'b0;
      end else begin
         if (rel_accept) begin
            mem[tail[IDX_W-1:0]] <= rel_preg;
            tail                 <= tail + 1'b1;
         end
         if (rel_valid && !rel_accept) begin
            overflow_err <= 1'b1;
         end
         retire_head <= retire_next;
         if (flush) begin
            spec_head <= retire_next;
         end else if (grant) begin
            spec_head <= spec_head + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_phys_free_list.sv
// Directed self-checking bench for phys_free_list (default build, or with FREELIST_BYPASS_EN defined).
module tb_phys_free_list;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       alloc_req = 1'b0;
   logic       alloc_valid;
   logic [4:0] alloc_preg;
   logic       rel_valid = 1'b0;
   logic [4:0] rel_preg = '0;
   logic       commit_valid = 1'b0;
   logic       flush = 1'b0;
   logic [4:0] free_count;
   logic       overflow_err;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   int          outstanding = 0;

   phys_free_list #(
      .NUM_ARCH_REGS(16),
      .NUM_PHYS_REGS(32),
      .PREG_W(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .alloc_req(alloc_req),
      .alloc_valid(alloc_valid),
      .alloc_preg(alloc_preg),
      .rel_valid(rel_valid),
      .rel_preg(rel_preg),
      .commit_valid(commit_valid),
      .flush(flush),
      .free_count(free_count),
      .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   // Granted-but-unretired allocations, tracked from observed handshakes.
   always @(posedge clk) begin
      if (reset || flush) outstanding <= 0;
      else outstanding <= outstanding + int'(alloc_req & alloc_valid) - int'(commit_valid);
   end

   task automatic check(input string tag, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; alloc_req = 0; rel_valid = 0; rel_preg = '0; commit_valid = 0; flush = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      tick();
      reset = 0;
      #1;
   endtask

   task automatic grant_n(input int n, input int first);
      for (int i = 0; i < n; i++) begin
         alloc_req = 1;
         #1;
         check("grant_valid", int'(alloc_valid), 1);
         check("grant_preg", int'(alloc_preg), first + i);
         tick();
      end
      alloc_req = 0;
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, int'(alloc_valid), 1);
      check({tag, "_preg"}, int'(alloc_preg), 16);
      check({tag, "_count"}, int'(free_count), 16);
      check({tag, "_ovf"}, int'(overflow_err), 0);
   endtask

   initial begin
      #10000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset state
      #1;
      tick();
      idle();
      #1;
      check_reset_state("rst");

      // 2: drain all 16, then an ignored request on empty
      grant_n(16, 16);
      check("empty_valid", int'(alloc_valid), 0);
      check("empty_count", int'(free_count), 0);
      alloc_req = 1;
      tick();
      alloc_req = 0;
      #1;
      check("empty_req_count", int'(free_count), 0);
      check("empty_req_ovf", int'(overflow_err), 0);

      // 3: release into empty list with a concurrent request
      rel_valid = 1; rel_preg = 5; alloc_req = 1;
      #1;
`ifdef FREELIST_BYPASS_EN
      check("byp_valid", int'(alloc_valid), 1);
      check("byp_preg", int'(alloc_preg), 5);
      tick();
      idle();
      #1;
      check("byp_count", int'(free_count), 0);
      check("byp_valid_after", int'(alloc_valid), 0);
`else
      check("nobyp_valid", int'(alloc_valid), 0);
      tick();
      idle();
      #1;
      check("nobyp_valid_next", int'(alloc_valid), 1);
      check("nobyp_preg_next", int'(alloc_preg), 5);
      check("nobyp_count_next", int'(free_count), 1);
`endif

      // 4: grant 3, retire 1, flush with a suppressed request
      do_reset();
      grant_n(3, 16);
      check("outstanding_before_commit", int'(outstanding != 0), 1);
      commit_valid = 1;
      tick();
      commit_valid = 0;
      flush = 1; alloc_req = 1;
      tick();
      idle();
      #1;
      check("flush_preg", int'(alloc_preg), 17);
      check("flush_count", int'(free_count), 15);

      // 4b: commit in the same cycle as flush is honoured first
      do_reset();
      grant_n(2, 16);
      check("outstanding_before_commit2", int'(outstanding != 0), 1);
      commit_valid = 1; flush = 1;
      tick();
      idle();
      #1;
      check("flushc_preg", int'(alloc_preg), 17);
      check("flushc_count", int'(free_count), 15);

      // 5: release at full is dropped and flagged
      do_reset();
      rel_valid = 1; rel_preg = 3;
      tick();
      idle();
      #1;
      check("ovf_flag", int'(overflow_err), 1);
      check("ovf_count", int'(free_count), 16);
      check("ovf_preg", int'(alloc_preg), 16);
      tick();
      check("ovf_sticky", int'(overflow_err), 1);

      // 5b: alloc + release at full is a net-zero exchange
      do_reset();
      alloc_req = 1; rel_valid = 1; rel_preg = 3;
      #1;
      check("xchg_preg", int'(alloc_preg), 16);
      tick();
      idle();
      #1;
      check("xchg_count", int'(free_count), 16);
      check("xchg_ovf", int'(overflow_err), 0);
      grant_n(15, 17);
      check("xchg_tail_preg", int'(alloc_preg), 3);
      check("xchg_tail_count", int'(free_count), 1);

      // 6: reset wins over flush, alloc and release
      do_reset();
      grant_n(5, 16);
      reset = 1; flush = 1; alloc_req = 1; rel_valid = 1; rel_preg = 9;
      tick();
      idle();
      #1;
      check_reset_state("rst2");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/phys_free_list.md
Name: phys_free_list

Overview:
Physical-register free list feeding the RegisterRenaming stage of the Tomasulo core.
- Supplies one free physical register per cycle to rename on an allocate handshake.
- Takes back freed physical registers from commit.
- Keeps a speculative head and a retirement head, so a flush returns every speculatively allocated register in one cycle.

Parameters:
NUM_ARCH_REGS, 16, architectural registers; after reset, arch reg i maps to phys reg i in rename.
NUM_PHYS_REGS, 32, physical registers.
PREG_W, 5, physical register index width.
DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGS (16), free-list capacity.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
alloc_req  in  1  rename requests one free phys reg this cycle.
alloc_valid  out  1  a free reg is available this cycle.
alloc_preg  out  PREG_W  free reg offered to rename, valid when alloc_valid=1.
rel_valid  in  1  commit returns a freed phys reg.
rel_preg  in  PREG_W  freed phys reg index.
commit_valid  in  1  an instruction that allocated a reg retires this cycle.
flush  in  1  squash all speculative allocations.
free_count  out  $clog2(DEPTH)+1  number of speculatively free entries.
overflow_err  out  1  sticky: a release was dropped because the list was full.

Behaviour:
Storage and pointers:
- Circular buffer mem[DEPTH].
- Pointers spec_head, retire_head, tail, each with an extra wrap bit.
- count = tail - spec_head.

Reset (synchronous):
- mem[i] = NUM_ARCH_REGS+i.
- spec_head = retire_head = 0; tail = DEPTH (wrap bit set, index 0).
- overflow_err = 0.
- Resulting outputs: alloc_valid=1, alloc_preg=16, free_count=16.
- Reset overrides every other input in the same cycle, including mid-flush or mid-burst.

Allocate:
- alloc_valid = (count!=0); alloc_preg = mem[spec_head]. Both combinational from state.
- Grant = alloc_req & alloc_valid & ~flush.
- On grant, spec_head++ at the posedge; the next reg appears next cycle.
- alloc_req while alloc_valid=0 is ignored: no pop, no error.

Release:
- rel_valid writes mem[tail] = rel_preg and increments tail.
- If count==DEPTH and there is no grant in the same cycle: write dropped, overflow_err set (sticky until reset), pointers unchanged.
- Full with a simultaneous grant is a legal net-zero exchange.

Retire:
- commit_valid increments retire_head.
- commit_valid must only be asserted for instructions that received a grant. Asserting it when retire_head==spec_head is illegal; the bench flags it.

Flush:
- spec_head <= retire_head, using retire_head after any same-cycle commit_valid increment.
- Any same-cycle release is still applied.
- Grant is suppressed in the flush cycle.
- The next cycle, count = tail - retire_head.

Simultaneous events, all within a single posedge, applied in this order: reset > (release, retire) > flush > grant.

Invariants:
- retire_head <= spec_head <= tail, modulo wrap.
- free_count equals count after every edge.

Width rules:
- Pointer arithmetic is modulo 2*DEPTH.
- free_count never exceeds DEPTH.

Optional Feature:
Macro FREELIST_BYPASS_EN.
- Defined: when count==0, rel_valid=1 and alloc_req=1, then alloc_valid=1 and alloc_preg=rel_preg combinationally in the same cycle. At the posedge, the entry is written at tail and consumed, so tail and spec_head both advance and count stays 0.
- Not defined: alloc_valid=0 in that cycle; the released reg is offered on the following cycle.

Test Plan:
1. Reset asserted one cycle -> alloc_valid=1, alloc_preg=16, free_count=16, overflow_err=0.
2. 16 consecutive cycles of alloc_req -> alloc_preg 16,17,...,31; then alloc_valid=0, free_count=0; 17th request causes no pointer change.
3. Empty list, rel_valid with rel_preg=5 plus alloc_req -> without macro: alloc_valid=0 that cycle, next cycle alloc_preg=5, free_count=1. With FREELIST_BYPASS_EN: alloc_preg=5 the same cycle, free_count stays 0.
4. From reset: grant 3 (16,17,18), commit_valid once, then flush -> next cycle alloc_preg=17, free_count=15; grant suppressed during the flush cycle.
5. At reset (full), rel_valid with rel_preg=3 and no alloc_req -> overflow_err=1, free_count=16, mem unchanged; a same-cycle alloc+release at full instead gives free_count=16, overflow_err=0.
6. After 5 grants, assert reset together with flush, alloc_req and rel_valid -> next cycle matches the post-reset state of test 1.
